// File: rtl/sub_operand_issue.sv
// Operand-issue stage for the external 32-bit subtractor: operand FIFO feeding sub_a/sub_b, registered result slot.
// Optional ALU flags are built only when SUB_FLAGS_EN is defined; otherwise out_flags is tied to zero.
module sub_operand_issue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [WIDTH-1:0]       sub_a,
    output logic [WIDTH-1:0]       sub_b,
    input  logic [WIDTH-1:0]       sub_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_c,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and in_ready depends only on registered state and rst.

    logic [WIDTH-1:0] a_mem_q   [DEPTH];
    logic [WIDTH-1:0] b_mem_q   [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             not_empty;
    logic             push;
    logic             fire;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [TAG_W-1:0] head_tag;

    assign not_empty = (count_q != '0);
    assign in_ready  = !rst && (count_q < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign fire      = not_empty && (!out_valid_q || out_ready);

    assign head_a   = a_mem_q[rd_ptr_q];
    assign head_b   = b_mem_q[rd_ptr_q];
    assign head_tag = tag_mem_q[rd_ptr_q];

    // Stale storage must not leak onto the subtractor once the FIFO drains.
    assign sub_a = not_empty ? head_a : '0;
    assign sub_b = not_empty ? head_b : '0;

    assign out_valid  = out_valid_q;
    assign out_c      = out_c_q;
    assign out_tag    = out_tag_q;
    assign fifo_count = count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (fire) begin
                out_valid_d = 1'b1;
                out_c_d     = sub_c;
                out_tag_d   = head_tag;
            end else if (out_ready && out_valid_q) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem_q[wr_ptr_q]   <= in_a;
            b_mem_q[wr_ptr_q]   <= in_b;
            tag_mem_q[wr_ptr_q] <= in_tag;
        end
    end

`ifdef SUB_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic       flag_zero, flag_neg, flag_borrow, flag_ovf;

    assign flag_zero   = (sub_c == '0);
    assign flag_neg    = sub_c[WIDTH-1];
    assign flag_borrow = (head_a < head_b);
    assign flag_ovf    = (head_a[WIDTH-1] != head_b[WIDTH-1]) && (sub_c[WIDTH-1] != head_a[WIDTH-1]);

    always_comb begin
        flags_d = flags_q;
        if (!flush && fire) flags_d = {flag_ovf, flag_borrow, flag_neg, flag_zero};
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= 4'b0;
        else     flags_q <= flags_d;
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 4'b0;
`endif

endmodule

// File: tb/tb_sub_operand_issue.sv
// Directed self-checking bench for sub_operand_issue; the bench plays the role of the combinational subtractor.
module tb_sub_operand_issue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
`ifdef SUB_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic [WIDTH-1:0] sub_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;
    logic [2:0]       fifo_count;

    int checks = 0;
    int errors = 0;

    // Flag vectors: {a, b, expected c, expected {ovf,borrow,neg,zero}}
    localparam logic [31:0] FA [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0005, 32'h0000_0001};
    localparam logic [31:0] FB [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'h8000_0000};
    localparam logic [31:0] FC [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001};
    localparam logic [3:0]  FF [4] = '{4'b0110, 4'b1000, 4'b0001, 4'b1110};

    // Backpressure vectors, tags 2..7
    localparam logic [31:0] BA [6] = '{32'd100, 32'd7, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'd50};
    localparam logic [31:0] BB [6] = '{32'd1, 32'd9, 32'h0234_5678, 32'd0, 32'd1, 32'd8};
    localparam logic [31:0] BC [6] = '{32'd99, 32'hFFFF_FFFE, 32'h1000_0000, 32'd0, 32'hFFFF_FFFE, 32'd42};

    sub_operand_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_c      (sub_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .fifo_count (fifo_count)
    );

    assign sub_c = sub_a - sub_b;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        step(); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        checks++; if (out_c !== 32'h0) begin errors++; $display("FAIL reset_out_c got %0h exp 0", out_c); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %0h exp 0", out_tag); end
        checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_out_flags got %0h exp 0", out_flags); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (sub_a !== 32'h0 || sub_b !== 32'h0) begin errors++; $display("FAIL reset_sub_ab got %0h/%0h exp 0/0", sub_a, sub_b); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0h exp 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd10; in_b = 32'd3; in_tag = 4'd1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0h exp 0", out_valid); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", fifo_count); end
        checks++; if (sub_a !== 32'd10 || sub_b !== 32'd3) begin errors++; $display("FAIL single_sub_ab got %0h/%0h exp a/3", sub_a, sub_b); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", out_valid); end
        checks++; if (out_c !== 32'd7) begin errors++; $display("FAIL single_out_c got %0h exp 7", out_c); end
        checks++; if (out_tag !== 4'd1) begin errors++; $display("FAIL single_out_tag got %0h exp 1", out_tag); end
        checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL single_flags got %b exp 0000", out_flags); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_drain got %0d exp 0", fifo_count); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got %0h exp 0", out_valid); end
    endtask

    task automatic test_flags();
        logic [3:0] exp_f;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = FA[i]; in_b = FB[i]; in_tag = 4'(i + 10);
            step();
            in_valid = 1'b0;
            step();
            exp_f = FLAGS_ON ? FF[i] : 4'b0000;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flags_valid[%0d] got %0h exp 1", i, out_valid); end
            checks++; if (out_c !== FC[i]) begin errors++; $display("FAIL flags_out_c[%0d] got %0h exp %0h", i, out_c, FC[i]); end
            checks++; if (out_tag !== 4'(i + 10)) begin errors++; $display("FAIL flags_tag[%0d] got %0h exp %0h", i, out_tag, i + 10); end
            checks++; if (out_flags !== exp_f) begin errors++; $display("FAIL flags_bits[%0d] got %b exp %b", i, out_flags, exp_f); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int  got;
        int  cyc;
        bit  pushed;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = BA[i]; in_b = BB[i]; in_tag = 4'(i + 2);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept[%0d] got %0h exp 1", i, in_ready); end
            step();
        end
        in_valid = 1'b1; in_a = BA[5]; in_b = BB[5]; in_tag = 4'd7;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %0h exp 0", in_ready); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d exp 4", fifo_count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got %0h exp 1", out_valid); end
        step(); step();
        checks++; if (out_c !== BC[0] || out_tag !== 4'd2) begin errors++; $display("FAIL bp_hold got %0h/%0h exp %0h/2", out_c, out_tag, BC[0]); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %0h exp 0", in_ready); end
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 20) begin
            pushed = in_valid && in_ready;
            if (out_valid) begin
                checks++; if (out_c !== BC[got] || out_tag !== 4'(got + 2)) begin errors++; $display("FAIL bp_result[%0d] got %0h/%0h exp %0h/%0h", got, out_c, out_tag, BC[got], got + 2); end
                got++;
            end else begin
                checks++; errors++; $display("FAIL bp_gap[%0d] got out_valid 0 exp 1", got);
            end
            step();
            cyc++;
            if (pushed) in_valid = 1'b0;
        end
        checks++; if (got !== 6) begin errors++; $display("FAIL bp_result_count got %0d exp 6", got); end
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0d/%0h exp 0/0", fifo_count, out_valid); end
    endtask

    task automatic test_stream();
        logic [WIDTH+TAG_W-1:0] exp_q[$];
        logic [WIDTH+TAG_W-1:0] exp_v;
        int  sent;
        int  got;
        int  cyc;
        bit  accepted;
        out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0;
        in_valid = 1'b1; in_a = 32'd1000; in_b = 32'd0; in_tag = 4'd0;
        while (got < 16 && cyc < 60) begin
            accepted = in_valid && in_ready;
            if (in_valid) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0h exp 1", sent, in_ready); end
            end
            if (accepted) exp_q.push_back({4'(sent), 32'd1000 + 32'(4 * sent)});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL stream_unexpected got %0h exp none", out_c);
                end else begin
                    exp_v = exp_q.pop_front();
                    checks++; if ({out_tag, out_c} !== exp_v) begin errors++; $display("FAIL stream_result[%0d] got %0h exp %0h", got, {out_tag, out_c}, exp_v); end
                end
                got++;
            end else if (got > 0) begin
                checks++; errors++; $display("FAIL stream_gap[%0d] got out_valid 0 exp 1", got);
            end
            step();
            cyc++;
            if (accepted) begin
                sent++;
                if (sent < 16) begin
                    in_a = 32'd1000 + 32'(7 * sent); in_b = 32'(3 * sent); in_tag = 4'(sent);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++; if (got !== 16) begin errors++; $display("FAIL stream_count got %0d exp 16", got); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL stream_fifo_empty got %0d exp 0", fifo_count); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_leftover got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_flush_or_rst(input bit use_rst);
        string nm;
        nm = use_rst ? "rst" : "flush";
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 32'(200 + i); in_b = 32'(i); in_tag = 4'(8 + i);
            step();
        end
        checks++; if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL %s_setup got %0d/%0h exp 3/1", nm, fifo_count, out_valid); end
        in_valid = 1'b1; in_a = 32'd77; in_b = 32'd7; in_tag = 4'd15;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        #1;
        if (use_rst) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_cycle_in_ready got %0h exp 0", in_ready); end
        end
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got %0h exp 0", nm, out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL %s_count got %0d exp 0", nm, fifo_count); end
        checks++; if (sub_a !== 32'h0) begin errors++; $display("FAIL %s_sub_a got %0h exp 0", nm, sub_a); end
        step(); step();
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL %s_dropped got %0h/%0d exp 0/0", nm, out_valid, fifo_count); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd20; in_b = 32'd5; in_tag = 4'd9;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_c !== 32'd15 || out_tag !== 4'd9) begin errors++; $display("FAIL %s_recover got %0h/%0h/%0h exp 1/f/9", nm, out_valid, out_c, out_tag); end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_flags();
        test_backpressure();
        test_stream();
        test_flush_or_rst(1'b0);
        test_flush_or_rst(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
